rr_trace_marshaller2: RTL and testbench

// - Two-input node of the record-side marshaller tree; inverse of the decoder's two-way split.
// - Joins packet A (left, lower channels) and packet B (right, higher channels) in lockstep.
// - Emits one compacted packet: B's valid payload packed directly above A's valid payload.
// - Output is registered through a 2-entry skid stage, so nodes cascade toward the tree root.

---
 rtl/rr_trace_marshaller2.sv | 178 +++++++++++++++++
 tb/tb_rr_trace_marshaller2.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_trace_marshaller2.sv
// rr_trace_marshaller2
//   Two-input node of the record-side marshaller tree. Joins packet A (lower
//   channels) and packet B (higher channels) in lockstep and emits one
//   compacted packet with B's valid payload packed directly above A's.
//   The output is registered through a 2-entry skid stage (main M + skid S),
//   so input ready never depends combinationally on out_ready.
//
// Ports
//   clk, rstn                     clock, synchronous active-low reset
//   inA_valid/_ready              A handshake (lower channels)
//   inA_logb_valid/_data          A per-channel valid, payload packed from bit 0
//   inA_loge_valid                A loge valid bits
//   inB_*                         same for B (higher channels)
//   out_valid/_ready              joined packet handshake
//   out_logb_valid                {inB_logb_valid, inA_logb_valid}
//   out_logb_data                 compacted payload
//   out_loge_valid                {inB_loge_valid, inA_loge_valid}
//   pkt_cnt                       output handshake count, wraps at 2^32

package rr_trace_marshaller2_pkg;
    // Sum of elements [lo, hi) of a flattened array of elem_bits-wide widths.
    function automatic int sum_w(input bit [1023:0] flat, input int elem_bits,
                                 input int lo, input int hi);
        int total;
        total = 0;
        for (int i = lo; i < hi; i++) begin
            int v;
            v = 0;
            for (int b = 0; b < elem_bits; b++) begin
                if (flat[i*elem_bits + b]) v = v + (1 << b);
            end
            total = total + v;
        end
        return total;
    endfunction
endpackage

module rr_trace_marshaller2 #(
    parameter int RR_CHANNEL_WIDTH_BITS = 8,
    parameter int LEFT_CNT              = 2,
    parameter int RIGHT_CNT             = 1,
    parameter bit [LEFT_CNT+RIGHT_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS =
        {8'd4, 8'd16, 8'd8},
    parameter int LOGE_A_CNT            = 2,
    parameter int LOGE_B_CNT            = 1,
    localparam int NCH   = LEFT_CNT + RIGHT_CNT,
    localparam int NLOGE = LOGE_A_CNT + LOGE_B_CNT,
    localparam int LW    = rr_trace_marshaller2_pkg::sum_w(1024'(CHANNEL_WIDTHS),
                               RR_CHANNEL_WIDTH_BITS, 0, LEFT_CNT),
    localparam int RW    = rr_trace_marshaller2_pkg::sum_w(1024'(CHANNEL_WIDTHS),
                               RR_CHANNEL_WIDTH_BITS, LEFT_CNT, NCH),
    localparam int FW    = LW + RW,
    localparam int LENW  = $clog2(FW + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  inA_valid,
    input  logic [LEFT_CNT-1:0]   inA_logb_valid,
    input  logic [LW-1:0]         inA_logb_data,
    input  logic [LOGE_A_CNT-1:0] inA_loge_valid,
    output logic                  inA_ready,
    input  logic                  inB_valid,
    input  logic [RIGHT_CNT-1:0]  inB_logb_valid,
    input  logic [RW-1:0]         inB_logb_data,
    input  logic [LOGE_B_CNT-1:0] inB_loge_valid,
    output logic                  inB_ready,
    output logic                  out_valid,
    output logic [NCH-1:0]        out_logb_valid,
    output logic [FW-1:0]         out_logb_data,
    output logic [NLOGE-1:0]      out_loge_valid,
    input  logic                  out_ready,
    output logic [31:0]           pkt_cnt
);

    typedef struct packed {
        logic [NCH-1:0]   lv;
        logic [FW-1:0]    data;
        logic [NLOGE-1:0] le;
    } pkt_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t      state_q, state_d;
    pkt_t        m_q, m_d;      // main register, drives the outputs (oldest)
    pkt_t        s_q, s_d;      // skid register, holds the newer packet when FULL
    logic [31:0] cnt_q, cnt_d;

    logic            space;
    logic            join_ok;
    logic            pop;
    logic [LENW-1:0] len_a;
    logic [LW-1:0]   a_mask;
    logic [FW-1:0]   payload;
    pkt_t            in_pkt;

    // Ready comes from the registered state only; no path from out_ready.
    assign space     = (state_q != FULL);
    assign join_ok   = rstn && inA_valid && inB_valid && space;
    assign inA_ready = rstn && inB_valid && space;
    assign inB_ready = rstn && inA_valid && space;
    assign pop       = (state_q != EMPTY) && out_ready;

    // Length of A's valid payload; bounded by LW so it cannot overflow LENW.
    always_comb begin
        len_a = '0;
        for (int i = 0; i < LEFT_CNT; i++) begin
            if (inA_logb_valid[i]) len_a = len_a + LENW'(CHANNEL_WIDTHS[i]);
        end
    end

    always_comb begin
        a_mask = '0;
        for (int i = 0; i < LW; i++) begin
            a_mask[i] = (i < int'(len_a));
        end
    end

    // B lands directly above A's valid bits; B is assumed zero above its own
    // length, so nothing leaks above lenA+lenB.
    assign payload = FW'(inA_logb_data & a_mask) | (FW'(inB_logb_data) << len_a);

    assign in_pkt.lv   = {inB_logb_valid, inA_logb_valid};
    assign in_pkt.data = payload;
    assign in_pkt.le   = {inB_loge_valid, inA_loge_valid};

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        if (pop) cnt_d = cnt_q + 32'd1;
        case (state_q)
            EMPTY: begin
                if (join_ok) begin
                    m_d     = in_pkt;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (join_ok && !out_ready) begin
                    s_d     = in_pkt;
                    state_d = FULL;
                end else if (join_ok) begin
                    m_d = in_pkt;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    m_d     = s_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (!rstn) begin
            state_d = EMPTY;
            m_d     = '0;
            s_d     = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        m_q     <= m_d;
        s_q     <= s_d;
        cnt_q   <= cnt_d;
    end

    assign out_valid      = (state_q != EMPTY);
    assign out_logb_valid = m_q.lv;
    assign out_logb_data  = m_q.data;
    assign out_loge_valid = m_q.le;
    assign pkt_cnt        = cnt_q;

endmodule

// File: tb/tb_rr_trace_marshaller2.sv
// Bench for rr_trace_marshaller2 with default parameters (widths 8,16 | 4).
// The reference is a queue of expected packets (capacity 2) plus a handshake
// counter; every cycle the DUT outputs are compared against it.
module tb_rr_trace_marshaller2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        a_v, b_v, out_ready;
    logic [1:0]  a_lv, a_le;
    logic [23:0] a_d;
    logic        b_lv, b_le;
    logic [3:0]  b_d;
    logic        ina_rdy, inb_rdy, out_valid;
    logic [2:0]  out_lv, out_le;
    logic [27:0] out_d;
    logic [31:0] pkt_cnt;

    always #5 clk = ~clk;

    rr_trace_marshaller2 dut (
        .clk(clk), .rstn(rstn),
        .inA_valid(a_v), .inA_logb_valid(a_lv), .inA_logb_data(a_d),
        .inA_loge_valid(a_le), .inA_ready(ina_rdy),
        .inB_valid(b_v), .inB_logb_valid(b_lv), .inB_logb_data(b_d),
        .inB_loge_valid(b_le), .inB_ready(inb_rdy),
        .out_valid(out_valid), .out_logb_valid(out_lv), .out_logb_data(out_d),
        .out_loge_valid(out_le), .out_ready(out_ready), .pkt_cnt(pkt_cnt)
    );

    typedef struct {
        logic [2:0]  lv;
        logic [27:0] d;
        logic [2:0]  le;
    } pkt_t;

    pkt_t        q[$];
    int unsigned exp_cnt;
    int          errs = 0;
    int          checks = 0;
    int          wch[3] = '{8, 16, 4};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected output packet for the inputs currently driven.
    function automatic pkt_t model_pkt();
        pkt_t  p;
        int    la;
        longint unsigned r;
        la = 0;
        for (int i = 0; i < 2; i++) if (a_lv[i]) la += wch[i];
        r = (longint'(a_d) & ((64'd1 << la) - 1)) | (longint'(b_d) << la);
        p.lv = {b_lv, a_lv};
        p.d  = r[27:0];
        p.le = {b_le, a_le};
        return p;
    endfunction

    // Compare at #1 after the negedge, then advance the model across posedge.
    task automatic cycle(output bit joined);
        bit   pop;
        pkt_t e;
        #1;
        chk("inA_ready", ina_rdy, rstn && b_v && (q.size() < 2));
        chk("inB_ready", inb_rdy, rstn && a_v && (q.size() < 2));
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            e = q[0];
            chk("out_logb_valid", out_lv, e.lv);
            chk("out_logb_data", out_d, e.d);
            chk("out_loge_valid", out_le, e.le);
        end
        chk("pkt_cnt", pkt_cnt, exp_cnt);
        joined = rstn && a_v && b_v && (q.size() < 2);
        pop    = (q.size() > 0) && out_ready;
        e      = model_pkt();
        @(posedge clk);
        if (!rstn) begin
            q.delete();
            exp_cnt = 0;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                exp_cnt++;
            end
            if (joined) q.push_back(e);
        end
        @(negedge clk);
    endtask

    // Random payload respecting "zero above own length".
    task automatic rnd_payload();
        int la;
        a_lv = 2'($urandom_range(0, 3));
        la = 0;
        for (int i = 0; i < 2; i++) if (a_lv[i]) la += wch[i];
        a_d  = 24'(longint'($urandom) & ((64'd1 << la) - 1));
        b_lv = 1'($urandom_range(0, 1));
        b_d  = b_lv ? 4'($urandom) : 4'h0;
        a_le = 2'($urandom);
        b_le = 1'($urandom);
    endtask

    task automatic drain();
        bit j;
        a_v = 0; b_v = 0; out_ready = 1;
        for (int i = 0; i < 4; i++) cycle(j);
    endtask

    task automatic do_reset();
        bit j;
        rstn = 0;
        cycle(j);
        rstn = 1;
    endtask

    initial begin
        bit j;
        int k;
        int bound;
        rstn = 0; a_v = 0; b_v = 0; out_ready = 1;
        a_lv = 0; a_d = 0; a_le = 0; b_lv = 0; b_d = 0; b_le = 0;
        q.delete(); exp_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        // Reset state
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_pkt_cnt", pkt_cnt, 0);
        chk("reset_inA_ready", ina_rdy, 0);
        do_reset();

        // Single join
        a_v = 1; b_v = 1; a_lv = 2'b10; a_d = 24'h00BEEF; b_lv = 1; b_d = 4'hA;
        a_le = 2'b00; b_le = 0;
        cycle(j);
        chk("single_valid", out_valid, 1);
        chk("single_lv", out_lv, 3'b110);
        chk("single_data", out_d, 28'h00ABEEF);
        drain();

        // A all-valid
        a_v = 1; b_v = 1; a_lv = 2'b11; a_d = 24'hBEEF5A; b_lv = 1; b_d = 4'h3;
        cycle(j);
        chk("allvalid_data", out_d, 28'h3BEEF5A);
        drain();

        // Empty payload
        a_v = 1; b_v = 1; a_lv = 0; a_d = 0; b_lv = 0; b_d = 0; a_le = 2'b01; b_le = 1;
        cycle(j);
        chk("empty_valid", out_valid, 1);
        chk("empty_data", out_d, 28'h0);
        chk("empty_loge", out_le, 3'b101);
        drain();

        // Join stall
        a_v = 1; b_v = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(j);
            chk("stall_inA_ready", ina_rdy, 0);
            chk("stall_out_valid", out_valid, 0);
        end
        b_v = 1;
        #1;
        chk("stall_release_A", ina_rdy, 1);
        chk("stall_release_B", inb_rdy, 1);
        cycle(j);
        drain();

        // Backpressure: 4 packets, out_ready low for 3 cycles
        do_reset();
        out_ready = 0; a_v = 1; b_v = 1; k = 0;
        for (int i = 0; i < 3; i++) begin
            rnd_payload();
            cycle(j);
            if (j) k++;
        end
        chk("bp_accepted", k, 2);
        chk("bp_full_inA_ready", ina_rdy, 0);
        chk("bp_full_inB_ready", inb_rdy, 0);
        chk("bp_out_valid", out_valid, 1);
        out_ready = 1;
        bound = 0;
        while (k < 4 && bound < 20) begin
            rnd_payload();
            cycle(j);
            if (j) k++;
            bound++;
        end
        chk("bp_all_sent", k, 4);
        drain();
        chk("bp_pkt_cnt", pkt_cnt, 4);

        // Reset mid-stream with a full buffer
        out_ready = 0; a_v = 1; b_v = 1;
        for (int i = 0; i < 3; i++) begin
            rnd_payload();
            cycle(j);
        end
        chk("mid_full_inA_ready", ina_rdy, 0);
        do_reset();
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_pkt_cnt", pkt_cnt, 0);
        a_v = 0; b_v = 0; out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            cycle(j);
            chk("mid_no_stale", out_valid, 0);
        end

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            rnd_payload();
            a_v       = ($urandom_range(0, 9) < 7);
            b_v       = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            rstn      = ($urandom_range(0, 99) != 0);
            cycle(j);
        end
        rstn = 1;
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
